// File: rtl/branch_resolve_unit.sv
// In-order queue of branch predictions between fetch and execute. It checks each
// resolved branch against its prediction and issues registered flush/redirect and predictor updates.
module branch_resolve_unit #(
  parameter int N = 32,
  parameter int D = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_valid,
  output logic                push_ready,
  input  logic [N-1:0]        push_pc,
  input  logic [1:0]          push_ctr,
  input  logic [N-1:0]        push_target,
  input  logic                res_valid,
  input  logic                res_taken,
  input  logic [N-1:0]        res_target,
  output logic                flush,
  output logic [N-1:0]        redirect_pc,
  output logic                upd_valid,
  output logic [N-1:0]        upd_pc,
  output logic                upd_taken,
  output logic [$clog2(D):0]  count,
  output logic                err_underflow
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [N-1:0]  pc_mem  [D];
  logic [N-1:0]  tgt_mem [D];
  logic [D-1:0]  pred_mem;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [CW-1:0] count_r;

  logic          flush_r;
  logic          upd_valid_r;
  logic          upd_taken_r;
  logic          err_r;
  logic [N-1:0]  redirect_r;
  logic [N-1:0]  upd_pc_r;

  logic          pop_s;
  logic          push_s;
  logic          mispredict_s;
  logic          underflow_s;
  logic          head_pred_s;
  logic [N-1:0]  head_pc_s;
  logic [N-1:0]  head_tgt_s;
  logic [N-1:0]  redirect_s;

  // Only the counter MSB (predicted direction) matters once the branch is queued.
  logic          unused_ctr_lsb;
  assign unused_ctr_lsb = push_ctr[0];

  function automatic logic is_mispredict(input logic         pred_taken,
                                         input logic [N-1:0] pred_target,
                                         input logic         act_taken,
                                         input logic [N-1:0] act_target);
    return (pred_taken != act_taken) ||
           (pred_taken && act_taken && (pred_target != act_target));
  endfunction

  // Head decode, pop/push qualification and redirect target selection.
  always_comb begin
    push_ready   = (count_r < CW'(D));
    head_pc_s    = pc_mem[head_r];
    head_tgt_s   = tgt_mem[head_r];
    head_pred_s  = pred_mem[head_r];
    pop_s        = res_valid && (count_r != {CW{1'b0}});
    underflow_s  = res_valid && (count_r == {CW{1'b0}});
    mispredict_s = pop_s && is_mispredict(head_pred_s, head_tgt_s, res_taken, res_target);
    // A push alongside a mispredicting resolve is wrong-path and is dropped.
    push_s       = push_valid && push_ready && !mispredict_s;
    if (res_taken) begin
      redirect_s = res_target;
    end else begin
      redirect_s = head_pc_s + N'(32'd4);
    end
  end

  // Record storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem[tail_r]   <= push_pc;
      tgt_mem[tail_r]  <= push_target;
      pred_mem[tail_r] <= push_ctr[1];
    end
  end

  // Queue pointers and occupancy; a mispredict empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {AW{1'b0}};
      tail_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (mispredict_s) begin
      head_r  <= tail_r;
      count_r <= {CW{1'b0}};
    end else begin
      if (pop_s) begin
        head_r <= head_r + AW'(1'b1);
      end
      if (push_s) begin
        tail_r <= tail_r + AW'(1'b1);
      end
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  // Registered resolve results; data outputs hold between resolves.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_r     <= 1'b0;
      upd_valid_r <= 1'b0;
      upd_taken_r <= 1'b0;
      upd_pc_r    <= {N{1'b0}};
      redirect_r  <= {N{1'b0}};
      err_r       <= 1'b0;
    end else begin
      flush_r     <= mispredict_s;
      upd_valid_r <= pop_s;
      if (pop_s) begin
        upd_pc_r    <= head_pc_s;
        upd_taken_r <= res_taken;
        redirect_r  <= redirect_s;
      end
      if (underflow_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign flush         = flush_r;
  assign redirect_pc   = redirect_r;
  assign upd_valid     = upd_valid_r;
  assign upd_pc        = upd_pc_r;
  assign upd_taken     = upd_taken_r;
  assign count         = count_r;
  assign err_underflow = err_r;

endmodule
